// File: rtl/regbank_mux_rd.sv
// Register bank with one write port and a registered read port. Both ports use one-hot selects.
// REGBANK_BYPASS_EN: when defined, a same-cycle read of the register being written returns wdata.
module regbank_mux_rd #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [DEPTH-1:0] wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic [DEPTH-1:0] rsel,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    output logic             sel_err
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             we_legal_c;
    logic             rd_legal_c;
    logic [WIDTH-1:0] mux_c;
    logic [WIDTH-1:0] rd_data_c;

    // A vector with exactly one bit set clears to zero when ANDed with itself minus one.
    function automatic logic is_onehot(input logic [DEPTH-1:0] v);
        return (v != '0) && ((v & (v - DEPTH'(1))) == '0);
    endfunction

    always_comb begin
        we_legal_c = we && is_onehot(wsel);
        rd_legal_c = rd_en && is_onehot(rsel);
    end

    // AND-OR read tree: every register is masked by its select bit, then all are ORed together.
    always_comb begin
        mux_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mux_c = mux_c | (regs[i] & {WIDTH{rsel[i]}});
        end
    end

    // Force zero on an illegal select, so a multi-hot OR never reaches res.
    always_comb begin
        rd_data_c = rd_legal_c ? mux_c : '0;
`ifdef REGBANK_BYPASS_EN
        if (we_legal_c && rd_legal_c && (wsel == rsel)) begin
            rd_data_c = wdata;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (we_legal_c && wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res       <= '0;
            res_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            if (rd_en) begin
                res <= rd_data_c;
            end
            res_valid <= rd_legal_c;
            sel_err   <= (we && !we_legal_c) || (rd_en && !rd_legal_c);
        end
    end

endmodule

// File: tb/tb_regbank_mux_rd.sv
// Bench for regbank_mux_rd: a behavioural model of the 16x8 bank with per-cycle compare,
// directed literal checks, and a small directed check of a 32x16 instance.
module tb_regbank_mux_rd;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0, rd_en = 1'b0;
    logic [15:0] wsel = '0, rsel = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  res;
    logic        res_valid, sel_err;

    logic        b_we = 1'b0, b_rd_en = 1'b0;
    logic [31:0] b_wsel = '0, b_rsel = '0;
    logic [15:0] b_wdata = '0;
    logic [15:0] b_res;
    logic        b_res_valid, b_sel_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    logic [7:0] mem [16];
    logic [7:0] exp_res;
    logic       exp_valid, exp_err;

    always #5 clk = ~clk;

    regbank_mux_rd dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wsel(wsel), .wdata(wdata),
        .rd_en(rd_en), .rsel(rsel), .res(res), .res_valid(res_valid), .sel_err(sel_err)
    );

    regbank_mux_rd #(.DEPTH(32), .WIDTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .we(b_we), .wsel(b_wsel), .wdata(b_wdata),
        .rd_en(b_rd_en), .rsel(b_rsel), .res(b_res), .res_valid(b_res_valid),
        .sel_err(b_sel_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit decode(input logic [15:0] v, output int idx);
        int n;
        n = 0;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                n++;
                idx = i;
            end
        end
        return n == 1;
    endfunction

    // Reference model: register array plus expected outputs, updated from the inputs at each edge.
    always @(posedge clk or negedge reset_n) begin
        int  wi, ri;
        bit  wl, rl;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'h00;
            exp_res   = 8'h00;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            wl = decode(wsel, wi);
            rl = decode(rsel, ri);
            exp_err = (we && !wl) || (rd_en && !rl);
            exp_valid = rd_en && rl;
            if (rd_en) begin
                exp_res = rl ? mem[ri] : 8'h00;
`ifdef REGBANK_BYPASS_EN
                if (rl && we && wl && wi == ri) exp_res = wdata;
`endif
            end
            if (we && wl) mem[wi] = wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("res", 32'(res), 32'(exp_res));
            check("res_valid", 32'(res_valid), 32'(exp_valid));
            check("sel_err", 32'(sel_err), 32'(exp_err));
        end
    end

    task automatic drive(input logic w, input logic [15:0] ws, input logic [7:0] wd,
                         input logic r, input logic [15:0] rs);
        @(negedge clk);
        we = w; wsel = ws; wdata = wd; rd_en = r; rsel = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic w, input logic [31:0] ws, input logic [15:0] wd,
                           input logic r, input logic [31:0] rs);
        @(negedge clk);
        b_we = w; b_wsel = ws; b_wdata = wd; b_rd_en = r; b_rsel = rs;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] gen_sel();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return 16'(1) << $urandom_range(0, 15);
        if (r == 7) return 16'h0000;
        return 16'($urandom);
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // Reset arriving mid-read, with an illegal write pending to raise sel_err.
        drive(1'b1, 16'h0008, 8'h5A, 1'b0, 16'h0000);
        drive(1'b1, 16'h0003, 8'hFF, 1'b1, 16'h0008);
        check("pre_reset_res", 32'(res), 32'h5A);
        check("pre_reset_err", 32'(sel_err), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_res", 32'(res), 32'h0);
        check("async_valid", 32'(res_valid), 32'h0);
        check("async_err", 32'(sel_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 16'h0000, 8'h00, 1'b1, 16'(1) << i);
            check("post_reset_zero", 32'(res), 32'h0);
        end

        // Write then read.
        drive(1'b1, 16'h0020, 8'hA5, 1'b0, 16'h0000);
        drive(1'b1, 16'h8000, 8'h3C, 1'b0, 16'h0000);
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0020);
        check("rd_reg5", 32'(res), 32'hA5);
        check("rd_reg5_valid", 32'(res_valid), 32'h1);
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 16'h8000);
        check("rd_reg15", 32'(res), 32'h3C);

        // Illegal selects.
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000);
        check("zero_rsel_res", 32'(res), 32'h0);
        check("zero_rsel_valid", 32'(res_valid), 32'h0);
        check("zero_rsel_err", 32'(sel_err), 32'h1);
        drive(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        check("err_pulse_end", 32'(sel_err), 32'h0);
        drive(1'b1, 16'h0003, 8'hFF, 1'b0, 16'h0000);
        check("multi_wsel_err", 32'(sel_err), 32'h1);
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0001);
        check("reg0_unchanged", 32'(res), 32'h0);
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0002);
        check("reg1_unchanged", 32'(res), 32'h0);

        // Same-cycle write/read collision on reg2.
        drive(1'b1, 16'h0004, 8'h11, 1'b0, 16'h0000);
        drive(1'b1, 16'h0004, 8'h22, 1'b1, 16'h0004);
`ifdef REGBANK_BYPASS_EN
        check("collision_bypass", 32'(res), 32'h22);
`else
        check("collision_rbw", 32'(res), 32'h11);
`endif
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0004);
        check("collision_after", 32'(res), 32'h22);

        // Hold with rd_en low.
        drive(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0020);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
            check("hold_res", 32'(res), 32'hA5);
            check("hold_valid", 32'(res_valid), 32'h0);
        end

        // 32x16 instance: far register and alternating back-to-back reads.
        drive_b(1'b1, 32'h8000_0000, 16'hBEEF, 1'b0, 32'h0);
        drive_b(1'b1, 32'h0000_0001, 16'h1234, 1'b0, 32'h0);
        drive_b(1'b0, 32'h0, 16'h0, 1'b1, 32'h8000_0000);
        check("b_reg31", 32'(b_res), 32'hBEEF);
        for (int i = 0; i < 6; i++) begin
            drive_b(1'b0, 32'h0, 16'h0, 1'b1, (i % 2 == 0) ? 32'h0000_0001 : 32'h8000_0000);
            check("b_alt_res", 32'(b_res), (i % 2 == 0) ? 32'h1234 : 32'hBEEF);
            check("b_alt_valid", 32'(b_res_valid), 32'h1);
        end

        // Randomised traffic, with an occasional mid-cycle reset.
        for (int n = 0; n < 2000; n++) begin
            drive(1'($urandom), gen_sel(), 8'($urandom), 1'($urandom), gen_sel());
            if ($urandom_range(0, 199) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        drive(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
